// File: rtl/auth_access_controller_pkg.sv
// Shared types for the credential access controller: FSM states, bus widths, grant priority encoder.
package auth_ctrl_pkg;

  localparam int CRED_W = 6;
  localparam int LVL_W  = 3;

  typedef enum logic [2:0] {IDLE, EVAL, GRANT, DENY, LOCKOUT} state_t;

  // Highest comparator level wins: bit2 > bit1 > bit0.
  function automatic logic [LVL_W-1:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
    logic [LVL_W-1:0] oh;
    oh = '0;
    if (lvl[2])      oh = 3'b100;
    else if (lvl[1]) oh = 3'b010;
    else if (lvl[0]) oh = 3'b001;
    return oh;
  endfunction

endpackage

// File: rtl/auth_access_controller_if.sv
// Access-controller bus: credential/submit/comparator level in, latched credential and access status out.
// Purely combinational bundle; no flow control beyond the submit level and the busy indication.
interface auth_access_controller_if #(
  parameter int MAX_FAILS = 3
);
  import auth_ctrl_pkg::*;

  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic [CRED_W-1:0] cred_in;
  logic              submit;
  logic [LVL_W-1:0]  aut_lvl;
  logic [CRED_W-1:0] cred_out;
  logic              busy;
  logic [LVL_W-1:0]  grant;
  logic              deny;
  logic              locked;
  logic [FCW-1:0]    fail_cnt;

  modport master (
    output cred_in, submit, aut_lvl,
    input  cred_out, busy, grant, deny, locked, fail_cnt
  );

  modport slave (
    input  cred_in, submit, aut_lvl,
    output cred_out, busy, grant, deny, locked, fail_cnt
  );

endinterface

// File: rtl/auth_access_controller_timer.sv
// auth_timer: loadable down-counter shared by the settle, grant and lockout phases.
// Load takes effect next clock; tick decrements and holds at zero; zero flag is decoded from the register.
module auth_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/auth_access_controller.sv
// Credential authentication sequencer: latch, settle, sample comparator, timed grant / deny / lockout.
// Result lands SETTLE_CYCLES clocks after acceptance; submit is ignored while busy. AUTH_SUBMIT_SYNC_EN adds a synchronized edge-detected submit.
module auth_access_controller
  import auth_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int GRANT_CYCLES  = 8,
  parameter int LOCK_CYCLES   = 16,
  parameter int MAX_FAILS     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  auth_access_controller_if.slave  bus
);

  localparam int FCW  = $clog2(MAX_FAILS + 1);
  localparam int MAXC = (SETTLE_CYCLES > GRANT_CYCLES)
                        ? ((SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES)
                        : ((GRANT_CYCLES  > LOCK_CYCLES) ? GRANT_CYCLES  : LOCK_CYCLES);
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t            state, state_next;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic [LVL_W-1:0]  grant_q, grant_d;
  logic              deny_q, deny_d;
  logic              locked_q, locked_d;
  logic              busy_q;
  logic [FCW-1:0]    fail_q, fail_d;
  logic              tmr_load, tmr_tick, tmr_zero;
  logic [TW-1:0]     tmr_value;
  logic              submit_go;

`ifdef AUTH_SUBMIT_SYNC_EN
  // Asynchronous button: two-flop synchronizer, then one acceptance per rising edge.
  logic sync1, sync2, sync_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= bus.submit;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign submit_go = sync2 & ~sync_prev;
`else
  assign submit_go = bus.submit;
`endif

  auth_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .tick    (tmr_tick),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_next = state;
    cred_d     = cred_q;
    grant_d    = grant_q;
    deny_d     = deny_q;
    locked_d   = locked_q;
    fail_d     = fail_q;
    tmr_load   = 1'b0;
    tmr_tick   = 1'b0;
    tmr_value  = '0;
    case (state)
      IDLE: begin
        if (submit_go) begin
          cred_d     = bus.cred_in;
          tmr_load   = 1'b1;
          tmr_value  = TW'(SETTLE_CYCLES - 1);
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (!tmr_zero) begin
          tmr_tick = 1'b1;
        end else if (bus.aut_lvl != '0) begin
          grant_d    = lvl_onehot(bus.aut_lvl);
          fail_d     = '0;
          tmr_load   = 1'b1;
          tmr_value  = TW'(GRANT_CYCLES - 1);
          state_next = GRANT;
        end else if ((fail_q + FCW'(1)) == FCW'(MAX_FAILS)) begin
          fail_d     = FCW'(MAX_FAILS);
          locked_d   = 1'b1;
          tmr_load   = 1'b1;
          tmr_value  = TW'(LOCK_CYCLES - 1);
          state_next = LOCKOUT;
        end else begin
          // fail_q < MAX_FAILS-1 here, so the increment never reaches saturation.
          fail_d     = fail_q + FCW'(1);
          deny_d     = 1'b1;
          state_next = DENY;
        end
      end
      GRANT: begin
        if (!tmr_zero) begin
          tmr_tick = 1'b1;
        end else begin
          grant_d    = '0;
          state_next = IDLE;
        end
      end
      DENY: begin
        deny_d     = 1'b0;
        state_next = IDLE;
      end
      LOCKOUT: begin
        if (!tmr_zero) begin
          tmr_tick = 1'b1;
        end else begin
          fail_d     = '0;
          locked_d   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cred_q   <= '0;
      grant_q  <= '0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      state    <= state_next;
      cred_q   <= cred_d;
      grant_q  <= grant_d;
      deny_q   <= deny_d;
      locked_q <= locked_d;
      busy_q   <= (state_next != IDLE);
      fail_q   <= fail_d;
    end
  end

  assign bus.cred_out = cred_q;
  assign bus.busy     = busy_q;
  assign bus.grant    = grant_q;
  assign bus.deny     = deny_q;
  assign bus.locked   = locked_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_auth_access_controller.sv
// Directed bench for auth_access_controller: expected outcomes queued at submit, compared when the DUT reports.
// Default build covers grant/deny/lockout/held-submit/reset; AUTH_SUBMIT_SYNC_EN covers the synchronized submit path.
module tb_auth_access_controller;

  localparam int SETTLE = 2;
  localparam int GRANTC = 8;
  localparam int LOCKC  = 16;
  localparam int MAXF   = 3;

  typedef struct {
    logic [2:0] grant;
    logic       deny;
    logic       locked;
    logic [1:0] fcnt;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb[$];
  int   model_fails;
  int   errors;
  int   checks;

  auth_access_controller_if #(.MAX_FAILS(MAXF)) bus ();

  auth_access_controller #(
    .SETTLE_CYCLES (SETTLE),
    .GRANT_CYCLES  (GRANTC),
    .LOCK_CYCLES   (LOCKC),
    .MAX_FAILS     (MAXF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cred_out"}, bus.cred_out, 0);
    chk({tag, "_busy"},     bus.busy,     0);
    chk({tag, "_grant"},    bus.grant,    0);
    chk({tag, "_deny"},     bus.deny,     0);
    chk({tag, "_locked"},   bus.locked,   0);
    chk({tag, "_fail_cnt"}, bus.fail_cnt, 0);
  endtask

  task automatic push_expect(input logic [2:0] lvl);
    exp_t e;
    e.grant  = 3'b000;
    e.deny   = 1'b0;
    e.locked = 1'b0;
    if (lvl != 3'b000) begin
      e.grant     = lvl[2] ? 3'b100 : (lvl[1] ? 3'b010 : 3'b001);
      model_fails = 0;
    end else if (model_fails + 1 == MAXF) begin
      e.locked    = 1'b1;
      model_fails = MAXF;
    end else begin
      e.deny      = 1'b1;
      model_fails = model_fails + 1;
    end
    e.fcnt = model_fails[1:0];
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after acceptance.
  task automatic submit_once(input logic [5:0] cred, input logic [2:0] lvl, input bit hold);
    bus.cred_in = cred;
    bus.aut_lvl = lvl;
    bus.submit  = 1'b1;
    push_expect(lvl);
    @(negedge clk);
    chk("cred_out_latch", bus.cred_out, cred);
    chk("busy_eval", bus.busy, 1);
    if (!hold) bus.submit = 1'b0;
    bus.cred_in = ~cred;
  endtask

  task automatic observe(input logic [5:0] cred, input bit scramble);
    exp_t e;
    int   n;
    int   cnt;
    n = 1;
    while (bus.grant == 3'b000 && !bus.deny && !bus.locked && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("result_latency", n, SETTLE + 1);
    chk("cred_out_frozen", bus.cred_out, cred);
    chk("sb_depth", sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant", bus.grant, e.grant);
    chk("deny", bus.deny, e.deny);
    chk("locked", bus.locked, e.locked);
    chk("fail_cnt", bus.fail_cnt, e.fcnt);
    cnt = 0;
    if (e.grant != 3'b000) begin
      while (bus.grant == e.grant && bus.busy && cnt < 100) begin
        cnt++;
        if (scramble) bus.aut_lvl = 3'($urandom_range(7, 0));
        @(negedge clk);
      end
      chk("grant_len", cnt, GRANTC);
      chk("grant_clear", bus.grant, 0);
    end else if (e.deny) begin
      while (bus.deny && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      chk("deny_len", cnt, 1);
    end else begin
      while (bus.locked && bus.busy && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      chk("lock_len", cnt, LOCKC);
      chk("lock_fail_clear", bus.fail_cnt, 0);
      model_fails = 0;
    end
    chk("busy_after", bus.busy, 0);
  endtask

  initial begin
    int evals;
    errors      = 0;
    checks      = 0;
    model_fails = 0;
    reset_n     = 1'b0;
    bus.cred_in = '0;
    bus.submit  = 1'b0;
    bus.aut_lvl = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

`ifdef AUTH_SUBMIT_SYNC_EN
    // Held button: acceptance two clocks late, then exactly one evaluation.
    bus.cred_in = 6'b110011;
    bus.aut_lvl = 3'b010;
    bus.submit  = 1'b1;
    push_expect(3'b010);
    @(negedge clk);
    chk("sync_busy_k1", bus.busy, 0);
    @(negedge clk);
    chk("sync_cred_k2", bus.cred_out, 0);
    chk("sync_busy_k2", bus.busy, 0);
    @(negedge clk);
    chk("sync_cred_k3", bus.cred_out, 6'b110011);
    chk("sync_busy_k3", bus.busy, 1);
    observe(6'b110011, 1'b0);
    evals = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) evals++;
      @(negedge clk);
    end
    chk("sync_no_retrigger", evals, 0);
    bus.submit = 1'b0;
`else
    // Top-level grant, then priority with comparator noise during GRANT.
    submit_once(6'b011000, 3'b100, 1'b0);
    observe(6'b011000, 1'b0);
    submit_once(6'b101010, 3'b011, 1'b0);
    observe(6'b101010, 1'b1);

    // Two denies, then lockout with submit held high throughout.
    submit_once(6'b000001, 3'b000, 1'b0);
    observe(6'b000001, 1'b0);
    submit_once(6'b000010, 3'b000, 1'b0);
    observe(6'b000010, 1'b0);
    submit_once(6'b000011, 3'b000, 1'b1);
    observe(6'b000011, 1'b0);

    // Held submit is taken again once IDLE, and stays held through the grant.
    bus.aut_lvl = 3'b001;
    push_expect(3'b001);
    @(negedge clk);
    chk("held_relatch_lock", bus.cred_out, 6'b111100);
    chk("held_busy_lock", bus.busy, 1);
    bus.cred_in = 6'b100101;
    observe(6'b111100, 1'b0);
    bus.aut_lvl = 3'b000;
    push_expect(3'b000);
    @(negedge clk);
    chk("held_relatch_grant", bus.cred_out, 6'b100101);
    chk("held_busy_grant", bus.busy, 1);
    bus.submit = 1'b0;
    observe(6'b100101, 1'b0);

    // Abort mid-EVAL with a nonzero failure count.
    bus.cred_in = 6'b010101;
    bus.aut_lvl = 3'b100;
    bus.submit  = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    chk("pre_reset_eval_busy", bus.busy, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("reset_eval");
    @(negedge clk);
    reset_n     = 1'b1;
    model_fails = 0;
    @(negedge clk);

    // Abort mid-LOCKOUT.
    submit_once(6'b001100, 3'b000, 1'b0);
    observe(6'b001100, 1'b0);
    submit_once(6'b001101, 3'b000, 1'b0);
    observe(6'b001101, 1'b0);
    submit_once(6'b001110, 3'b000, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_reset_locked", bus.locked, 1);
    chk("pre_reset_fail_cnt", bus.fail_cnt, MAXF);
    if (sb.size() != 0) void'(sb.pop_front());
    #2 reset_n = 1'b0;
    #1 chk_zero("reset_lock");
    @(negedge clk);
    reset_n     = 1'b1;
    model_fails = 0;
    @(negedge clk);

    submit_once(6'b111111, 3'b100, 1'b0);
    observe(6'b111111, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
